// File: rtl/multi_channel_watchdog.sv
// multi_channel_watchdog: NUM_CH independent heartbeat watchdogs with warning, trip, trip counters and a merged fault summary
module multi_channel_watchdog #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int WARN_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 12,
    parameter int STICKY         = 1,
    parameter int TRIP_CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            enable,
    input  logic [NUM_CH-1:0]            heartbeat,
    input  logic [NUM_CH-1:0]            force_trip,
    input  logic [NUM_CH-1:0]            clear,
    output logic [NUM_CH-1:0]            warning,
    output logic [NUM_CH-1:0]            triggered,
    output logic [NUM_CH-1:0]            trip_pulse,
    output logic [NUM_CH*TRIP_CNT_W-1:0] trip_count,
    output logic                         sys_fault,
    output logic [$clog2(NUM_CH)-1:0]    fault_ch
);
    typedef enum logic [1:0] {DISABLED, RUNNING, WARNING, TRIGGERED} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                state, nxt;
        logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
        logic [TRIP_CNT_W-1:0] tcnt;
        logic                  pulse;
        logic                  entry;

        // next-state selection in priority order: force, clear, enable, heartbeat, count
        always_comb begin
            cnt_inc = cnt + 1'b1;
            nxt     = state;
            cnt_nxt = cnt;
            if (force_trip[i])
                nxt = TRIGGERED;
            else if (state == TRIGGERED) begin
                if (clear[i]) begin
                    nxt     = enable[i] ? RUNNING : DISABLED;
                    cnt_nxt = '0;
                end else if (STICKY == 0 && !enable[i])
                    nxt = DISABLED;
                else if (STICKY == 0 && heartbeat[i]) begin
                    nxt     = RUNNING;
                    cnt_nxt = '0;
                end
            end else if (!enable[i] || state == DISABLED || heartbeat[i]) begin
                nxt     = enable[i] ? RUNNING : DISABLED;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_inc;
                nxt     = cnt_inc == CNT_W'(TIMEOUT_CYCLES) ? TRIGGERED :
                          cnt_inc == CNT_W'(WARN_CYCLES)    ? WARNING   : state;
            end
        end

        assign entry = nxt == TRIGGERED && state != TRIGGERED;

        // channel state, idle counter, entry pulse and saturating trip counter
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state <= DISABLED;
                cnt   <= '0;
                tcnt  <= '0;
                pulse <= 1'b0;
            end else begin
                state <= nxt;
                cnt   <= cnt_nxt;
                pulse <= entry;
                tcnt  <= entry && !(&tcnt) ? tcnt + 1'b1 : tcnt;
            end
        end

        assign warning[i]                          = state == WARNING;
        assign triggered[i]                        = state == TRIGGERED;
        assign trip_pulse[i]                       = pulse;
        assign trip_count[i*TRIP_CNT_W +: TRIP_CNT_W] = tcnt;
    end

    assign sys_fault = |triggered;

    // lowest-index tripped channel wins
    always_comb begin
        fault_ch = '0;
        for (int j = NUM_CH - 1; j >= 0; j--)
            fault_ch = triggered[j] ? ($clog2(NUM_CH))'(j) : fault_ch;
    end
endmodule

// File: tb/tb_multi_channel_watchdog.sv
// tb_multi_channel_watchdog: randomized and directed checks of sticky and non-sticky watchdogs against a behavioural model
module tb_multi_channel_watchdog;
    localparam int N  = 4;
    localparam int TW = 8;
    localparam int WC = 8;
    localparam int TC = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  en = '0, hb = '0, ft = '0, cl = '0;
    logic [N-1:0]  w [2];
    logic [N-1:0]  t [2];
    logic [N-1:0]  p [2];
    logic [N*TW-1:0] tc [2];
    logic          sf [2];
    logic [1:0]    fc [2];

    int checks = 0;
    int errors = 0;

    // k=0 instance is non-sticky, k=1 instance is sticky
    int  mq   [2][N];
    bit  mtrip[2][N];
    bit  marm [2][N];
    bit  mpul [2][N];
    int  mtc  [2][N];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        multi_channel_watchdog #(
            .NUM_CH(N), .CNT_W(32), .WARN_CYCLES(WC), .TIMEOUT_CYCLES(TC),
            .STICKY(k), .TRIP_CNT_W(TW)
        ) dut (
            .clk(clk), .rstn(rstn), .enable(en), .heartbeat(hb),
            .force_trip(ft), .clear(cl), .warning(w[k]), .triggered(t[k]),
            .trip_pulse(p[k]), .trip_count(tc[k]), .sys_fault(sf[k]), .fault_ch(fc[k])
        );
    end

    always #5 clk = ~clk;

    task automatic model_reset;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                mq[k][i] = 0; mtrip[k][i] = 0; marm[k][i] = 0; mpul[k][i] = 0; mtc[k][i] = 0;
            end
    endtask

    // armed = watching heartbeats, quiet = heartbeat-free cycles since arming or last kick
    task automatic model_step;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                bit was = mtrip[k][i];
                if (ft[i]) mtrip[k][i] = 1;
                else if (was) begin
                    if (cl[i]) begin mtrip[k][i] = 0; marm[k][i] = en[i]; mq[k][i] = 0; end
                    else if (k == 0 && !en[i]) begin mtrip[k][i] = 0; marm[k][i] = 0; end
                    else if (k == 0 && hb[i]) begin mtrip[k][i] = 0; marm[k][i] = 1; mq[k][i] = 0; end
                end else if (!en[i]) begin marm[k][i] = 0; mq[k][i] = 0; end
                else if (!marm[k][i]) begin marm[k][i] = 1; mq[k][i] = 0; end
                else if (hb[i]) mq[k][i] = 0;
                else begin
                    mq[k][i]++;
                    if (mq[k][i] == TC) mtrip[k][i] = 1;
                end
                mpul[k][i] = mtrip[k][i] && !was;
                if (mpul[k][i] && mtc[k][i] < 2**TW - 1) mtc[k][i]++;
            end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset;
        #2 rstn = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset;
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset;
        en = '0; hb = '0; ft = '0; cl = '0;
        rstn = 1'b0;
        model_reset();
        #12;
        checks++; if (w[1] !== 0 || t[1] !== 0 || p[1] !== 0) begin errors++; $display("FAIL reset_state w=%b t=%b p=%b want 0", w[1], t[1], p[1]); end
        checks++; if (tc[1] !== 0 || sf[1] !== 0 || fc[1] !== 0) begin errors++; $display("FAIL reset_count tc=%h sf=%b fc=%0d want 0", tc[1], sf[1], fc[1]); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        en[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 8) begin checks++; if (w[1][0] !== 1'b0) begin errors++; $display("FAIL warn_early edge8 got %b want 0", w[1][0]); end end
            if (e == 9) begin checks++; if (w[1][0] !== 1'b1) begin errors++; $display("FAIL warn_edge9 got %b want 1", w[1][0]); end end
            if (e == 12) begin checks++; if (t[1][0] !== 1'b0) begin errors++; $display("FAIL trip_early edge12 got %b want 0", t[1][0]); end end
            if (e == 13) begin
                checks++; if (t[1][0] !== 1'b1 || p[1][0] !== 1'b1) begin errors++; $display("FAIL trip_edge13 t=%b p=%b want 1 1", t[1][0], p[1][0]); end
                checks++; if (tc[1][TW-1:0] !== 8'd1) begin errors++; $display("FAIL trip_count0 got %0d want 1", tc[1][TW-1:0]); end
                checks++; if (sf[1] !== 1'b1 || fc[1] !== 2'd0) begin errors++; $display("FAIL fault_sum sf=%b fc=%0d want 1 0", sf[1], fc[1]); end
            end
            if (e == 14) begin checks++; if (p[1][0] !== 1'b0 || t[1][0] !== 1'b1) begin errors++; $display("FAIL pulse_width p=%b t=%b want 0 1", p[1][0], t[1][0]); end end
        end
        cl[0] = 1'b1; en[0] = 1'b0;
        tick();
        cl[0] = 1'b0;
    endtask

    task automatic test_heartbeat;
        bit seen = 0;
        en[1] = 1'b1;
        for (int c = 0; c < 70; c++) begin
            hb[1] = (c % 7 == 6);
            tick();
            checks++; if (w[1][1] !== 1'b0 || t[1][1] !== 1'b0) begin errors++; $display("FAIL hb_periodic cyc=%0d w=%b t=%b want 0 0", c, w[1][1], t[1][1]); end
        end
        hb[1] = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = w[1][1];
        end
        checks++; if (!seen) begin errors++; $display("FAIL hb_warn_reach got w=%b want 1", w[1][1]); end
        hb[1] = 1'b1;
        tick();
        checks++; if (w[1][1] !== 1'b0) begin errors++; $display("FAIL hb_warn_drop got %b want 0", w[1][1]); end
        hb[1] = 1'b0; en[1] = 1'b0;
        tick();
    endtask

    task automatic test_sticky;
        bit seen = 0;
        en[2] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = t[1][2];
        end
        checks++; if (!seen) begin errors++; $display("FAIL sticky_trip got t=%b want 1", t[1][2]); end
        en[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            hb[2] = c[0];
            tick();
            checks++; if (t[1][2] !== 1'b1) begin errors++; $display("FAIL sticky_hold cyc=%0d got %b want 1", c, t[1][2]); end
        end
        hb[2] = 1'b0; en[2] = 1'b1; cl[2] = 1'b1;
        tick();
        cl[2] = 1'b0;
        checks++; if (t[1][2] !== 1'b0 || w[1][2] !== 1'b0) begin errors++; $display("FAIL sticky_clear t=%b w=%b want 0 0", t[1][2], w[1][2]); end
        for (int e = 1; e <= TC; e++) begin
            tick();
            if (e == TC - 1) begin checks++; if (t[1][2] !== 1'b0) begin errors++; $display("FAIL retrip_early got %b want 0", t[1][2]); end end
        end
        checks++; if (t[1][2] !== 1'b1 || tc[1][2*TW +: TW] !== 8'd2) begin errors++; $display("FAIL retrip t=%b cnt=%0d want 1 2", t[1][2], tc[1][2*TW +: TW]); end
    endtask

    task automatic test_force_clear;
        int np = 0;
        ft[3] = 1'b1; cl[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            np += p[1][3];
        end
        ft[3] = 1'b0; cl[3] = 1'b0;
        checks++; if (t[1][3] !== 1'b1 || np != 1) begin errors++; $display("FAIL force_clear t=%b pulses=%0d want 1 1", t[1][3], np); end
        checks++; if (fc[1] !== 2'd2 || sf[1] !== 1'b1) begin errors++; $display("FAIL fault_ch_low fc=%0d sf=%b want 2 1", fc[1], sf[1]); end
        tick();
        checks++; if (t[1][3] !== 1'b1 || p[1][3] !== 1'b0) begin errors++; $display("FAIL force_after t=%b p=%b want 1 0", t[1][3], p[1][3]); end
        en[2] = 1'b0; cl[3:2] = 2'b11;
        tick();
        cl = '0;
        checks++; if (sf[1] !== 1'b0 || fc[1] !== 2'd0) begin errors++; $display("FAIL fault_cleared sf=%b fc=%0d want 0 0", sf[1], fc[1]); end
    endtask

    task automatic test_saturate;
        for (int c = 0; c < 256; c++) begin
            ft[0] = 1'b1;
            tick();
            ft[0] = 1'b0; cl[0] = 1'b1;
            tick();
            cl[0] = 1'b0;
        end
        checks++; if (tc[1][TW-1:0] !== 8'd255 || tc[0][TW-1:0] !== 8'd255) begin errors++; $display("FAIL saturate got %0d/%0d want 255", tc[1][TW-1:0], tc[0][TW-1:0]); end
    endtask

    task automatic test_async_reset;
        en[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        checks++; if (w[1][0] !== 1'b1) begin errors++; $display("FAIL pre_reset_warn got %b want 1", w[1][0]); end
        do_reset();
        checks++; if (w[1] !== 0 || t[1] !== 0 || tc[1] !== 0 || sf[1] !== 0 || w[0] !== 0 || tc[0] !== 0) begin errors++; $display("FAIL async_reset_warn w=%b t=%b tc=%h sf=%b want 0", w[1], t[1], tc[1], sf[1]); end
        release_reset();
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 8) begin checks++; if (w[1][0] !== 1'b0) begin errors++; $display("FAIL post_reset_early got %b want 0", w[1][0]); end end
        end
        checks++; if (w[1][0] !== 1'b1) begin errors++; $display("FAIL post_reset_run got %b want 1", w[1][0]); end
        ft[1] = 1'b1;
        tick();
        ft[1] = 1'b0;
        checks++; if (t[1][1] !== 1'b1) begin errors++; $display("FAIL pre_reset_trip got %b want 1", t[1][1]); end
        do_reset();
        checks++; if (t[1] !== 0 || p[1] !== 0 || tc[1] !== 0 || sf[1] !== 0 || fc[1] !== 0) begin errors++; $display("FAIL async_reset_trip t=%b p=%b tc=%h want 0", t[1], p[1], tc[1]); end
        release_reset();
        en = '0;
        tick();
    endtask

    task automatic test_nonsticky;
        bit seen = 0;
        en[0] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = t[0][0];
        end
        checks++; if (!seen) begin errors++; $display("FAIL nonsticky_trip got %b want 1", t[0][0]); end
        hb[0] = 1'b1;
        tick();
        hb[0] = 1'b0;
        checks++; if (t[0][0] !== 1'b0 || w[0][0] !== 1'b0 || t[1][0] !== 1'b1) begin errors++; $display("FAIL nonsticky_release t0=%b w0=%b t1=%b want 0 0 1", t[0][0], w[0][0], t[1][0]); end
        en = '0; cl = '1;
        tick();
        cl = '0;
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = $urandom_range(0, 15) != 0;
                hb[i] = $urandom_range(0, 9) == 0;
                ft[i] = $urandom_range(0, 59) == 0;
                cl[i] = $urandom_range(0, 14) == 0;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [N-1:0]    ew, et, ep;
                logic [N*TW-1:0] etc;
                logic [1:0]      efc = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    ew[i] = !mtrip[k][i] && marm[k][i] && mq[k][i] >= WC;
                    et[i] = mtrip[k][i];
                    ep[i] = mpul[k][i];
                    etc[i*TW +: TW] = TW'(mtc[k][i]);
                    if (mtrip[k][i]) efc = 2'(i);
                end
                checks++; if (w[k] !== ew || t[k] !== et || p[k] !== ep) begin errors++; $display("FAIL rand_state k=%0d cyc=%0d w=%b t=%b p=%b want %b %b %b", k, c, w[k], t[k], p[k], ew, et, ep); end
                checks++; if (tc[k] !== etc) begin errors++; $display("FAIL rand_count k=%0d cyc=%0d got %h want %h", k, c, tc[k], etc); end
                checks++; if (sf[k] !== |et || fc[k] !== efc) begin errors++; $display("FAIL rand_fault k=%0d cyc=%0d sf=%b fc=%0d want %b %0d", k, c, sf[k], fc[k], |et, efc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_heartbeat();
        test_sticky();
        test_force_clear();
        test_saturate();
        test_async_reset();
        test_nonsticky();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
